// File: rtl/am25s_shreg_if.sv
// am25s_shreg_if: data/control bundle for the universal shift register.
interface am25s_shreg_if #(parameter int WIDTH = 8);
    logic             ce_;
    logic [1:0]       s;
    logic [WIDTH-1:0] d;
    logic             sil;
    logic             sih;
    logic             rot;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_;
    modport master (output ce_, s, d, sil, sih, rot, input q, q_);
    modport slave (input ce_, s, d, sil, sih, rot, output q, q_);
endinterface

// File: rtl/am25s_shreg.sv
// am25s_shreg: universal shift/storage register with hold, shift up/down, load.
// Define AM25S_SHREG_ROTATE_EN to let rot turn the shifts into rotates.
module am25s_shreg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic clk,
    input  logic clr_,
    am25s_shreg_if.slave bus
);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] up;
    logic [WIDTH-1:0] dn;
    logic [WIDTH-1:0] nxt;
    logic             up_in;
    logic             dn_in;
`ifdef AM25S_SHREG_ROTATE_EN
    assign up_in = bus.rot ? q[WIDTH-1] : bus.sil;
    assign dn_in = bus.rot ? q[0] : bus.sih;
`else
    logic unused_rot;
    assign unused_rot = bus.rot;
    assign up_in = bus.sil;
    assign dn_in = bus.sih;
`endif
    // A one-bit register simply takes the serial input from either end.
    generate
        if (WIDTH == 1) begin : g_narrow
            assign up = up_in;
            assign dn = dn_in;
        end else begin : g_wide
            assign up = {q[WIDTH-2:0], up_in};
            assign dn = {dn_in, q[WIDTH-1:1]};
        end
    endgenerate
    always_comb begin
        nxt = bus.ce_      ? q     :
              bus.s == 2'b11 ? bus.d :
              bus.s == 2'b01 ? up    :
              bus.s == 2'b10 ? dn    : q;
    end
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) q <= CLR_VAL;
        else       q <= nxt;
    end
    assign bus.q  = q;
    assign bus.q_ = ~q;
endmodule

// File: tb/tb_am25s_shreg.sv
// tb_am25s_shreg: directed scoreboard bench for am25s_shreg (WIDTH 6, clear value 0).
module tb_am25s_shreg;
    localparam int W = 6;
    logic clk;
    logic clr_;
    bit   run_clk = 0;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] sb[$];
    am25s_shreg_if #(.WIDTH(W)) bus ();
    am25s_shreg #(.WIDTH(W), .CLR_VAL('0)) dut (.clk(clk), .clr_(clr_), .bus(bus));
    always #5 if (run_clk) clk = ~clk;
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic ce, input logic [1:0] s, input logic [W-1:0] d,
                         input logic sil, input logic sih, input logic rot, input logic [W-1:0] exp);
        bus.ce_ = ce;
        bus.s   = s;
        bus.d   = d;
        bus.sil = sil;
        bus.sih = sih;
        bus.rot = rot;
        sb.push_back(exp);
    endtask
    task automatic tick(input string tag);
        logic [W-1:0] exp;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            exp = sb.pop_front();
            chk(tag, bus.q, exp);
            chk({tag, "_n"}, bus.q_, ~exp);
        end
    endtask
    initial begin
        clk     = 1'bx;
        clr_    = 1'b0;
        bus.ce_ = 1'b0;
        bus.s   = 2'b11;
        bus.d   = 'x;
        bus.sil = 1'b0;
        bus.sih = 1'b0;
        bus.rot = 1'b0;
        #1;
        chk("clr_x", bus.q, 6'b000000);
        chk("clr_x_n", bus.q_, 6'b111111);
        clk = 1'b0;
        run_clk = 1;
        drive(0, 2'b11, 6'b101010, 0, 0, 0, 6'b000000);
        tick("clr_hold");
        clr_ = 1'b1;
        drive(0, 2'b11, 6'b111111, 0, 0, 0, 6'b111111);
        tick("ld_ff");
        drive(0, 2'b11, 6'b000000, 0, 0, 0, 6'b000000);
        tick("ld_00");
        drive(0, 2'b11, 6'b101010, 0, 0, 0, 6'b101010);
        tick("ld_aa");
        drive(0, 2'b11, 6'b010101, 0, 0, 0, 6'b010101);
        tick("ld_55");
        drive(0, 2'b11, 6'b101010, 0, 0, 0, 6'b101010);
        tick("ld_sh");
        drive(0, 2'b01, 6'b000000, 1, 0, 0, 6'b010101);
        tick("up_sil1");
        drive(0, 2'b01, 6'b111111, 0, 1, 0, 6'b101010);
        tick("up_sil0");
        drive(0, 2'b10, 6'b000000, 0, 1, 0, 6'b110101);
        tick("dn_sih1");
        drive(0, 2'b11, 6'b110011, 0, 0, 0, 6'b110011);
        tick("ld_hold");
        drive(0, 2'b00, 6'b000000, 1, 1, 0, 6'b110011);
        tick("hold");
        drive(1, 2'b11, 6'b000000, 1, 1, 0, 6'b110011);
        tick("ce_off");
        drive(1, 2'b01, 6'b000000, 1, 1, 0, 6'b110011);
        tick("ce_off_up");
        drive(0, 2'b11, 6'b111111, 0, 0, 0, 6'b111111);
        tick("ld_pre_clr");
        clr_ = 1'b0;
        #1;
        chk("clr_async", bus.q, 6'b000000);
        chk("clr_async_n", bus.q_, 6'b111111);
        drive(0, 2'b11, 6'b111111, 0, 0, 0, 6'b000000);
        // Release lands after the edge's evaluation, so the clear still owns this edge.
        @(posedge clk);
        clr_ <= 1'b1;
        #1;
        void'(sb.pop_front());
        chk("clr_release_edge", bus.q, 6'b000000);
        drive(0, 2'b11, 6'b111111, 0, 0, 0, 6'b111111);
        tick("ld_post_clr");
        drive(0, 2'b11, 6'b100001, 0, 0, 0, 6'b100001);
        tick("ld_rot");
`ifdef AM25S_SHREG_ROTATE_EN
        drive(0, 2'b01, 6'b000000, 0, 1, 1, 6'b000011);
        tick("rot_up");
        drive(0, 2'b10, 6'b000000, 1, 0, 1, 6'b100001);
        tick("rot_dn");
`else
        drive(0, 2'b01, 6'b000000, 0, 1, 1, 6'b000010);
        tick("rot_up_off");
        drive(0, 2'b10, 6'b000000, 1, 0, 1, 6'b000001);
        tick("rot_dn_off");
`endif
        drive(0, 2'b11, 6'b011110, 0, 0, 1, 6'b011110);
        tick("ld_rot_ignored");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
